// File: rtl/score_pkg.sv
// Shared constants, types and helpers for the score keeper.
// Optional high-score tracking in score_keeper is controlled by SCORE_HISCORE_EN.
package score_pkg;

    typedef logic [15:0] score_t;

    localparam int DEF_INIT_SCORE = 100;
    localparam int DEF_KILL_PTS   = 10;
    localparam int DEF_SELL_PTS   = 20;
    localparam int DEF_BUILD_COST = 30;

    // Event masks are zero-extended to this width before counting.
    localparam int POP_W = 64;

    // Number of set bits in v.
    function automatic logic [6:0] popcount(input logic [POP_W-1:0] v);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < POP_W; i++) begin
            c = c + 7'(v[i]);
        end
        return c;
    endfunction

    // Limit a signed sum to the range 0..hi.
    function automatic logic [31:0] clamp(input logic signed [31:0] v,
                                          input logic [31:0] hi);
        if (v < 0) begin
            return '0;
        end else if ($unsigned(v) > hi) begin
            return hi;
        end else begin
            return $unsigned(v);
        end
    endfunction

endpackage

// File: rtl/score_combo.sv
// Kill-combo multiplier and its reload/decay window timer.
// mult_next is the multiplier that applies to the kills of the current cycle.
module score_combo #(
    parameter int COMBO_WIN = 64,
    parameter int COMBO_MAX = 4,
    parameter int MW        = $clog2(COMBO_MAX + 1)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          en,
    input  logic          kill_any,
    output logic [MW-1:0] mult_next,
    output logic [MW-1:0] mult
);

    localparam int TW = $clog2(COMBO_WIN + 1);

    logic [MW-1:0] mult_q;
    logic [TW-1:0] timer_q, timer_d;

    // Next multiplier and timer: a kill inside the window raises the
    // multiplier, a kill outside it restarts at 1; the window decays on idle cycles.
    always_comb begin
        mult_next = mult_q;
        timer_d   = timer_q;
        if (en) begin
            if (kill_any) begin
                timer_d = TW'(COMBO_WIN);
                if (timer_q != '0) begin
                    if (mult_q >= MW'(COMBO_MAX)) begin
                        mult_next = MW'(COMBO_MAX);
                    end else begin
                        mult_next = mult_q + MW'(1);
                    end
                end else begin
                    mult_next = MW'(1);
                end
            end else if (timer_q != '0) begin
                timer_d = timer_q - TW'(1);
                if (timer_q == TW'(1)) begin
                    mult_next = MW'(1);
                end
            end
        end
    end

    // Multiplier and timer registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            mult_q  <= MW'(1);
            timer_q <= '0;
        end else begin
            mult_q  <= mult_next;
            timer_q <= timer_d;
        end
    end

    assign mult = mult_q;

endmodule

// File: rtl/score_keeper.sv
// Game-score accumulator: detects kills, builds and sells from occupancy
// bitmaps and applies weighted, combo-scaled, saturating score updates.
// Define SCORE_HISCORE_EN to add high-score tracking (hiscore, new_record, hiscore_clr).
module score_keeper
    import score_pkg::*;
#(
    parameter int N_MONS     = 16,
    parameter int N_TOWERS   = 8,
    parameter int SCORE_W    = 16,
    parameter int INIT_SCORE = DEF_INIT_SCORE,
    parameter int SCORE_MAX  = 9999,
    parameter int KILL_PTS   = DEF_KILL_PTS,
    parameter int SELL_PTS   = DEF_SELL_PTS,
    parameter int BUILD_COST = DEF_BUILD_COST,
    parameter int COMBO_WIN  = 64,
    parameter int COMBO_MAX  = 4,
    parameter int MW         = $clog2(COMBO_MAX + 1)
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                en,
    input  logic [N_MONS-1:0]   used_array,
    input  logic [N_TOWERS-1:0] fi_used_array,
`ifdef SCORE_HISCORE_EN
    input  logic                hiscore_clr,
    output logic [SCORE_W-1:0]  hiscore,
    output logic                new_record,
`endif
    output logic [SCORE_W-1:0]  score,
    output logic [MW-1:0]       combo_mult,
    output logic                afford,
    output logic                score_evt
);

    // Wide enough that the worst-case delta added to a full score cannot overflow.
    localparam int DW = SCORE_W + 8;
    localparam logic signed [DW-1:0] KILL_S  = DW'(KILL_PTS);
    localparam logic signed [DW-1:0] SELL_S  = DW'(SELL_PTS);
    localparam logic signed [DW-1:0] BUILD_S = DW'(BUILD_COST);

    logic [N_MONS-1:0]   prev_mons_q;
    logic [N_TOWERS-1:0] prev_tow_q;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic                score_evt_q;

    logic [N_MONS-1:0]   kill_m;
    logic [N_TOWERS-1:0] build_m, sell_m;
    logic [6:0]          nk, nb, ns;
    logic [MW-1:0]       mult_next, mult;

    logic signed [DW-1:0] nk_s, nb_s, ns_s, mult_s, delta, sum;

    // Per-slot transitions against the last accepted snapshot.
    always_comb begin
        kill_m  = prev_mons_q & ~used_array;
        build_m = ~prev_tow_q & fi_used_array;
        sell_m  = prev_tow_q & ~fi_used_array;
        nk      = popcount(POP_W'(kill_m));
        nb      = popcount(POP_W'(build_m));
        ns      = popcount(POP_W'(sell_m));
    end

    score_combo #(
        .COMBO_WIN (COMBO_WIN),
        .COMBO_MAX (COMBO_MAX),
        .MW        (MW)
    ) u_combo (
        .Clk       (Clk),
        .Reset     (Reset),
        .en        (en),
        .kill_any  (|kill_m),
        .mult_next (mult_next),
        .mult      (mult)
    );

    // Net signed delta of all events this cycle, then clamp into 0..SCORE_MAX.
    always_comb begin
        nk_s    = DW'(nk);
        nb_s    = DW'(nb);
        ns_s    = DW'(ns);
        mult_s  = DW'(mult_next);
        delta   = nk_s * KILL_S * mult_s + ns_s * SELL_S - nb_s * BUILD_S;
        sum     = DW'(score_q) + delta;
        score_d = SCORE_W'(clamp(32'(sum), 32'(SCORE_MAX)));
    end

    // Score, snapshots and update pulse; a pause holds everything.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            score_q     <= SCORE_W'(INIT_SCORE);
            prev_mons_q <= used_array;
            prev_tow_q  <= fi_used_array;
            score_evt_q <= 1'b0;
        end else if (en) begin
            score_q     <= score_d;
            prev_mons_q <= used_array;
            prev_tow_q  <= fi_used_array;
            score_evt_q <= (score_d != score_q);
        end else begin
            score_evt_q <= 1'b0;
        end
    end

`ifdef SCORE_HISCORE_EN
    logic [SCORE_W-1:0] hiscore_q;
    logic               new_record_q;

    // Best score seen; immune to Reset, cleared only by hiscore_clr.
    // A record only registers on a real score change, so it pulses with score_evt.
    always_ff @(posedge Clk) begin
        if (hiscore_clr) begin
            hiscore_q    <= '0;
            new_record_q <= 1'b0;
        end else if (!Reset && en && (score_d != score_q) && (score_d > hiscore_q)) begin
            hiscore_q    <= score_d;
            new_record_q <= 1'b1;
        end else begin
            new_record_q <= 1'b0;
        end
    end

    assign hiscore    = hiscore_q;
    assign new_record = new_record_q;
`endif

    assign score      = score_q;
    assign combo_mult = mult;
    assign afford     = (32'(score_q) >= 32'(BUILD_COST));
    assign score_evt  = score_evt_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with hand-computed expectations.
// Define SCORE_HISCORE_EN to also exercise the high-score ports.
module tb_score_keeper;
    import score_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        en;
    logic [15:0] used_array;
    logic [7:0]  fi_used_array;
    score_t      score;
    logic [2:0]  combo_mult;
    logic        afford;
    logic        score_evt;
`ifdef SCORE_HISCORE_EN
    logic        hiscore_clr;
    score_t      hiscore;
    logic        new_record;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    score_keeper dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .en            (en),
        .used_array    (used_array),
        .fi_used_array (fi_used_array),
`ifdef SCORE_HISCORE_EN
        .hiscore_clr   (hiscore_clr),
        .hiscore       (hiscore),
        .new_record    (new_record),
`endif
        .score         (score),
        .combo_mult    (combo_mult),
        .afford        (afford),
        .score_evt     (score_evt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    initial begin
        Reset = 1'b1; en = 1'b0; used_array = 16'h00FF; fi_used_array = 8'h00;
`ifdef SCORE_HISCORE_EN
        hiscore_clr = 1'b1;
`endif
        tick(2);
        Reset = 1'b0;
`ifdef SCORE_HISCORE_EN
        hiscore_clr = 1'b0;
`endif
        check("rst_score", 32'(score), 100);
        check("rst_mult", 32'(combo_mult), 1);
        check("rst_evt", 32'(score_evt), 0);
        check("rst_afford", 32'(afford), 1);

        // four kills at mult 1
        en = 1'b1;
        tick();
        check("idle_score", 32'(score), 100);
        check("idle_evt", 32'(score_evt), 0);
        used_array = 16'h00F0;
        tick();
        check("kill4_score", 32'(score), 140);
        check("kill4_evt", 32'(score_evt), 1);
        check("kill4_mult", 32'(combo_mult), 1);
        tick();
        check("kill4_evt_off", 32'(score_evt), 0);
        check("kill4_hold", 32'(score), 140);
        tick(69);
        check("win_expired_mult", 32'(combo_mult), 1);

        // combo: t, t+10 (mult 2), t+80 (window expired, mult 1)
        used_array = 16'h00E0;
        tick();
        check("combo1_score", 32'(score), 150);
        tick(9);
        used_array = 16'h00C0;
        tick();
        check("combo2_score", 32'(score), 170);
        check("combo2_mult", 32'(combo_mult), 2);
        tick(69);
        check("combo_decay_mult", 32'(combo_mult), 1);
        used_array = 16'h0080;
        tick();
        check("combo3_score", 32'(score), 180);
        check("combo3_mult", 32'(combo_mult), 1);

        // kill inside window -> mult 2, then reset mid-combo
        used_array = 16'h0000;
        tick();
        check("combo4_score", 32'(score), 200);
        check("combo4_mult", 32'(combo_mult), 2);
        Reset = 1'b1; used_array = 16'hFFFF;
        tick();
        Reset = 1'b0;
        check("midrst_score", 32'(score), 100);
        check("midrst_mult", 32'(combo_mult), 1);
        check("midrst_evt", 32'(score_evt), 0);
        tick();
        check("postrst_evt", 32'(score_evt), 0);
        check("postrst_score", 32'(score), 100);

        // builds: 100 -> 40, then 40 - 60 clamps to 0
        fi_used_array = 8'h03;
        tick();
        check("build2_score", 32'(score), 40);
        check("build2_afford", 32'(afford), 1);
        fi_used_array = 8'h0F;
        tick();
        check("clamp0_score", 32'(score), 0);
        check("clamp0_afford", 32'(afford), 0);
        check("clamp0_evt", 32'(score_evt), 1);

        // sell + build + kill in one cycle nets to zero
        fi_used_array = 8'h1E; used_array = 16'hFFFE;
        tick();
        check("net0_score", 32'(score), 0);
        check("net0_evt", 32'(score_evt), 0);

        // saturation at SCORE_MAX with mult ceiling
        used_array = 16'hFFFF;
        tick();
        for (int r = 0; r < 20; r++) begin
            used_array = 16'h0000;
            tick();
            used_array = 16'hFFFF;
            tick();
        end
        check("sat_score", 32'(score), 9999);
        check("sat_mult", 32'(combo_mult), 4);
        used_array = 16'h0000;
        tick();
        check("sat_nochg_evt", 32'(score_evt), 0);
        check("sat_nochg_score", 32'(score), 9999);

        // pause: three kills while en=0, scored as one update on resume
        Reset = 1'b1; used_array = 16'hFFFF;
        tick();
        Reset = 1'b0; en = 1'b0;
        used_array = 16'hFFFE;
        tick();
        used_array = 16'hFFFC;
        tick();
        used_array = 16'hFFF8;
        tick();
        check("pause_score", 32'(score), 100);
        check("pause_evt", 32'(score_evt), 0);
        en = 1'b1;
        tick();
        check("resume_score", 32'(score), 130);
        check("resume_evt", 32'(score_evt), 1);
        check("resume_mult", 32'(combo_mult), 1);
        tick();
        check("resume_evt_off", 32'(score_evt), 0);

`ifdef SCORE_HISCORE_EN
        hiscore_clr = 1'b1;
        tick();
        hiscore_clr = 1'b0;
        check("hs_clr0", 32'(hiscore), 0);
        used_array = 16'hFE00;
        tick();
        check("hs_250_score", 32'(score), 250);
        check("hs_250_hi", 32'(hiscore), 250);
        check("hs_250_rec", 32'(new_record), 1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("hs_rst_score", 32'(score), 100);
        check("hs_rst_hi", 32'(hiscore), 250);
        check("hs_rst_rec", 32'(new_record), 0);
        used_array = 16'h8000;
        tick();
        check("hs_160_score", 32'(score), 160);
        check("hs_160_rec", 32'(new_record), 0);
        used_array = 16'hFFFF;
        tick();
        used_array = 16'hFFE0;
        tick();
        check("hs_260_score", 32'(score), 260);
        check("hs_260_hi", 32'(hiscore), 260);
        check("hs_260_rec", 32'(new_record), 1);
        hiscore_clr = 1'b1;
        tick();
        hiscore_clr = 1'b0;
        check("hs_clr_hi", 32'(hiscore), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
